multiplicador_4b: RTL and testbench
===================================

Name: multiplicador_4b

Overview:
- Button-driven 4-bit multiplier front panel: the inverse operation of the team's divider panel.
- User enters multiplicand A, then multiplier B, with up/down/ok buttons.
- A sequential shift-add core forms the 8-bit product, shown on 4 LEDs as low nibble, then high nibble.
- Sits at board top level, driven directly by raw active-low push-buttons.

Parameters:
- W, 4, operand width; product is 2W bits, leds are W bits.
- SYNC_STAGES, 2, flip-flop stages per button synchronizer (minimum 2).

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  asynchronous, active-low reset.
- up  input  1  raw button, active-low; increments the operand being entered.
- down  input  1  raw button, active-low; decrements the operand being entered.
- ok  input  1  raw button, active-low; advances the phase.
- leds  output  W  display value.
- phase  output  3  current state encoding (see Behaviour).
- busy  output  1  high while the product is being computed.

Behaviour:
- Reset (rst=0, asynchronous): A=0, B=0, product=0, iteration count=0, state IN_A, leds=0, phase=0, busy=0. Synchronizer and edge registers reset to 1 (button released).
- Button events:
  - Each button passes through a SYNC_STAGES synchronizer, then a falling-edge detector.
  - Each detector emits a one-cycle event pulse SYNC_STAGES+1 cycles after the pin falls.
  - Holding a button produces exactly one event; no auto-repeat.
- States and phase encoding: IN_A=0, IN_B=1, CALC=2, SHOW_LO=3, SHOW_HI=4. Codes 5-7 are unreachable; if entered, next state is IN_A.
- IN_A:
  - leds=A.
  - up event: A+1, wrapping 15→0. down event: A−1, wrapping 0→15.
  - up and down in the same cycle: A unchanged.
  - ok event: go to IN_B.
- IN_B: same as IN_A but operates on B; leds=B.
- IN_B exit: an ok event loads the core (acc=0, mcand=A zero-extended to 2W, mplier=B, count=0) and goes to CALC.
- CALC:
  - busy=1, leds=0.
  - Each cycle: if mplier[0], acc += mcand. Then mcand <<= 1, mplier >>= 1, count++.
  - After exactly W cycles in CALC: product=acc, go to SHOW_LO.
  - All button events are ignored during CALC.
- SHOW_LO: leds=product[W-1:0]. ok event: go to SHOW_HI.
- SHOW_HI: leds=product[2W-1:W]. ok event: go to IN_A.
- Operand retention: A and B keep their values when the cycle returns to IN_A, so re-entry starts from the previous operands.
- up/down events in CALC, SHOW_LO and SHOW_HI are ignored.
- Outputs leds, phase and busy are registered; they update one cycle after the event or state change.
- Arithmetic:
  - Product is unsigned and exact: the maximum is 15×15=225=0xE1, with no overflow in 2W bits.
  - 0×n = 0; the core still takes W cycles.
- Reset mid-CALC aborts immediately to reset values; no partial product is retained.
- Simultaneous ok and up/down events in an entry state: apply the up/down update to the current operand in the same cycle as the transition.

Decomposition:
- Shared package holds:
  - phase constants (PH_IN_A, PH_IN_B, PH_CALC, PH_SHOW_LO, PH_SHOW_HI, 3-bit);
  - default W.
- Natural sub-module: multiplicador_iter, the shift-add core.
  - Inputs: clk, rst, start, a[W], b[W]. Outputs: product[2W], done.
  - done pulses for one cycle W cycles after start.
- The top-level FSM, synchronizers/edge detectors and leds mux stay in multiplicador_4b.

Test Plan:
- Reset: hold rst=0 with buttons released → leds=0, phase=0, busy=0; release rst, no presses → state unchanged.
- Entry and wrap: in IN_A, 3 down presses → A=13 (leds=0xD); 4 up presses → A=1. One press held 50 cycles → exactly one increment, observed SYNC_STAGES+1 cycles after press.
- Full multiply: A=13, B=11, press ok → busy=1 for exactly 4 cycles, then phase=3, leds=0xF (143=0x8F). ok → leds=0x8. ok → phase=0, leds=13 (A retained).
- Boundaries:
  - 15×15 → SHOW_LO leds=0x1, SHOW_HI leds=0xE.
  - 0×9 → 0x0 / 0x0 after 4 CALC cycles.
- Ignored inputs: press up/down/ok during CALC and up/down during SHOW states → product, operands and state sequence unaffected.
- Reset mid-CALC: assert rst=0 on CALC cycle 2 → immediate phase=0, A=B=0, leds=0, busy=0; a following 2×3 run yields 0x6 / 0x0.

Source files
------------

// File: rtl/multiplicador_4b_pkg.sv
// Shared constants for the button-driven multiplier panel.
// Holds the phase encodings shown on the phase output, the FSM state type
// built on them, and the default operand width.
package multiplicador_4b_pkg;

  localparam int unsigned W_DEF = 4;

  localparam logic [2:0] PH_IN_A    = 3'd0;
  localparam logic [2:0] PH_IN_B    = 3'd1;
  localparam logic [2:0] PH_CALC    = 3'd2;
  localparam logic [2:0] PH_SHOW_LO = 3'd3;
  localparam logic [2:0] PH_SHOW_HI = 3'd4;

  typedef enum logic [2:0] {
    ST_IN_A    = PH_IN_A,
    ST_IN_B    = PH_IN_B,
    ST_CALC    = PH_CALC,
    ST_SHOW_LO = PH_SHOW_LO,
    ST_SHOW_HI = PH_SHOW_HI
  } state_t;

endpackage

// File: rtl/multiplicador_iter.sv
// Sequential shift-add multiplier core.
// Ports:
//   clk, rst    clock, asynchronous active-low reset
//   start       one-cycle pulse; loads acc=0, mcand=a, mplier=b, count=0
//   a, b        W-bit unsigned operands, sampled with start
//   product     2W-bit result, updated when the last iteration completes
//   done        registered pulse, high in the W-th cycle after the start cycle
module multiplicador_iter #(
  parameter int unsigned W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic [2*W-1:0]   product,
  output logic             done
);

  localparam int unsigned PW = 2 * W;
  localparam int unsigned CW = $clog2(W + 1);

  logic [PW-1:0] acc_q;
  logic [PW-1:0] mcand_q;
  logic [W-1:0]  mplier_q;
  logic [CW-1:0] count_q;
  logic          running_q;

  logic [PW-1:0] src_acc;
  logic [PW-1:0] src_mcand;
  logic [W-1:0]  src_mplier;
  logic [CW-1:0] src_count;
  logic [PW-1:0] nxt_acc;
  logic [PW-1:0] nxt_mcand;
  logic [W-1:0]  nxt_mplier;
  logic [CW-1:0] nxt_count;

  // One iteration step. On start the loaded values feed the step directly,
  // so the first iteration lands on the load edge and W edges finish the job.
  always_comb begin
    src_acc    = start ? '0        : acc_q;
    src_mcand  = start ? PW'(a)    : mcand_q;
    src_mplier = start ? b         : mplier_q;
    src_count  = start ? '0        : count_q;
    nxt_acc    = src_mplier[0] ? (src_acc + src_mcand) : src_acc;
    nxt_mcand  = src_mcand << 1;
    nxt_mplier = src_mplier >> 1;
    nxt_count  = src_count + CW'(1);
  end

  // Datapath registers and completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      running_q <= 1'b0;
      product   <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start || running_q) begin
        acc_q    <= nxt_acc;
        mcand_q  <= nxt_mcand;
        mplier_q <= nxt_mplier;
        count_q  <= nxt_count;
        if (nxt_count == CW'(W)) begin
          product   <= nxt_acc;
          done      <= 1'b1;
          running_q <= 1'b0;
        end else begin
          running_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/multiplicador_4b.sv
// Button-driven 4-bit multiplier front panel.
// User enters A then B with up/down/ok, the shift-add core forms A*B, and
// the product is shown as low nibble then high nibble.
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   up, down, ok     raw active-low push-buttons
//   leds             displayed value (operand, zero while busy, or product nibble)
//   phase            current state code
//   busy             high while the product is being computed
module multiplicador_4b
  import multiplicador_4b_pkg::*;
#(
  parameter int unsigned W           = W_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up,
  input  logic         down,
  input  logic         ok,
  output logic [W-1:0] leds,
  output logic [2:0]   phase,
  output logic         busy
);

  // Button bit order inside the vectors below: {ok, down, up}.
  logic [2:0]                    btn;
  logic [SYNC_STAGES-1:0][2:0]   sync_q;
  logic [2:0]                    prev_q;
  logic [2:0]                    ev_q;

  logic ev_up;
  logic ev_down;
  logic ev_ok;

  state_t        state_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  b_upd;
  logic          start_c;
  logic [2*W-1:0] product;
  logic          done;

  assign btn     = {ok, down, up};
  assign ev_up   = ev_q[0];
  assign ev_down = ev_q[1];
  assign ev_ok   = ev_q[2];

  // Up/down step with wrap; simultaneous up and down cancel out.
  function automatic logic [W-1:0] bump(input logic [W-1:0] v,
                                        input logic inc,
                                        input logic dec);
    if (inc && !dec)      return v + W'(1);
    else if (dec && !inc) return v - W'(1);
    else                  return v;
  endfunction

  // Synchronizer chain, then a registered falling-edge detector per button.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
      prev_q <= '1;
      ev_q   <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
      prev_q <= sync_q[SYNC_STAGES-1];
      ev_q   <= prev_q & ~sync_q[SYNC_STAGES-1];
    end
  end

  // Core is launched with B including any same-cycle up/down update.
  always_comb begin
    b_upd   = bump(b_q, ev_up, ev_down);
    start_c = (state_q == ST_IN_B) && ev_ok;
  end

  multiplicador_iter #(.W(W)) u_iter (
    .clk     (clk),
    .rst     (rst),
    .start   (start_c),
    .a       (a_q),
    .b       (b_upd),
    .product (product),
    .done    (done)
  );

  // Panel FSM, operand registers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IN_A;
      a_q     <= '0;
      b_q     <= '0;
      leds    <= '0;
      phase   <= PH_IN_A;
      busy    <= 1'b0;
    end else begin
      case (state_q)
        ST_IN_A: begin
          a_q <= bump(a_q, ev_up, ev_down);
          if (ev_ok) state_q <= ST_IN_B;
        end
        ST_IN_B: begin
          b_q <= b_upd;
          if (ev_ok) state_q <= ST_CALC;
        end
        ST_CALC: begin
          if (done) state_q <= ST_SHOW_LO;
        end
        ST_SHOW_LO: begin
          if (ev_ok) state_q <= ST_SHOW_HI;
        end
        ST_SHOW_HI: begin
          if (ev_ok) state_q <= ST_IN_A;
        end
        default: state_q <= ST_IN_A;
      endcase

      // Outputs follow the current state, so they lag a state change by one cycle.
      phase <= state_q;
      busy  <= (state_q == ST_CALC);
      case (state_q)
        ST_IN_A:    leds <= a_q;
        ST_IN_B:    leds <= b_q;
        ST_SHOW_LO: leds <= product[W-1:0];
        ST_SHOW_HI: leds <= product[2*W-1:W];
        default:    leds <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador_4b.sv
// Directed bench for the multiplier panel: entry/wrap, held button, full
// multiplies with boundary operands, ignored inputs and reset mid-calculation.
module tb_multiplicador_4b;

  logic       clk = 1'b0;
  logic       rst;
  logic       up;
  logic       down;
  logic       ok;
  logic [3:0] leds;
  logic [2:0] phase;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  multiplicador_4b dut (
    .clk   (clk),
    .rst   (rst),
    .up    (up),
    .down  (down),
    .ok    (ok),
    .leds  (leds),
    .phase (phase),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // which: 0 = up, 1 = down, 2 = ok
  task automatic press(input int which);
    @(negedge clk);
    case (which)
      0: up = 1'b0;
      1: down = 1'b0;
      default: ok = 1'b0;
    endcase
    cyc(4);
    up = 1'b1; down = 1'b1; ok = 1'b1;
    cyc(8);
  endtask

  task automatic press_n(input int which, input int n);
    for (int i = 0; i < n; i++) press(which);
  endtask

  // Hold ok low from IN_B, count busy cycles until SHOW_LO appears, then walk the display.
  task automatic run_calc(input string tag, input logic [3:0] exp_lo,
                          input logic [3:0] exp_hi, input logic [3:0] exp_a);
    int nbusy;
    bit seen;
    nbusy = 0;
    seen  = 1'b0;
    @(negedge clk);
    ok = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (phase == 3'd3) seen = 1'b1;
    end
    ok = 1'b1;
    chk({tag, "_busy_cycles"}, 8'(nbusy), 8'd4);
    cyc(8);
    chk({tag, "_lo_phase"}, 8'(phase), 8'd3);
    chk({tag, "_lo"}, 8'(leds), 8'(exp_lo));
    press(2);
    chk({tag, "_hi_phase"}, 8'(phase), 8'd4);
    chk({tag, "_hi"}, 8'(leds), 8'(exp_hi));
    press(2);
    chk({tag, "_back_phase"}, 8'(phase), 8'd0);
    chk({tag, "_back_a"}, 8'(leds), 8'(exp_a));
  endtask

  initial begin
    int nbusy;
    bit seen;
    rst = 1'b0; up = 1'b1; down = 1'b1; ok = 1'b1;

    // Reset state
    cyc(3);
    chk("rst_leds", 8'(leds), 8'h0);
    chk("rst_phase", 8'(phase), 8'h0);
    chk("rst_busy", 8'(busy), 8'h0);
    rst = 1'b1;
    cyc(20);
    chk("idle_leds", 8'(leds), 8'h0);
    chk("idle_phase", 8'(phase), 8'h0);

    // Entry and wrap
    press_n(1, 3);
    chk("a_down_wrap", 8'(leds), 8'd13);
    press_n(0, 4);
    chk("a_up_wrap", 8'(leds), 8'd1);

    // Held press: one increment, pulse three cycles after the fall, leds one later
    @(negedge clk);
    up = 1'b0;
    cyc(4);
    chk("held_early", 8'(leds), 8'd1);
    cyc(1);
    chk("held_edge", 8'(leds), 8'd2);
    cyc(45);
    up = 1'b1;
    cyc(8);
    chk("held_once", 8'(leds), 8'd2);

    // 13 x 11 = 143 = 0x8F
    press_n(1, 5);
    chk("a_13", 8'(leds), 8'd13);
    press(2);
    chk("in_b_phase", 8'(phase), 8'd1);
    chk("b_start", 8'(leds), 8'd0);
    press_n(1, 5);
    chk("b_11", 8'(leds), 8'd11);
    run_calc("m13x11", 4'hF, 4'h8, 4'd13);

    // 15 x 15 = 225 = 0xE1
    press_n(0, 2);
    press(2);
    chk("b_kept", 8'(leds), 8'd11);
    press_n(0, 4);
    run_calc("m15x15", 4'h1, 4'hE, 4'd15);

    // 0 x 9 = 0
    press(0);
    chk("a_wrap_0", 8'(leds), 8'd0);
    press(2);
    press_n(1, 6);
    chk("b_9", 8'(leds), 8'd9);
    run_calc("m0x9", 4'h0, 4'h0, 4'd0);

    // 7 x 9 = 63 = 0x3F with up and a second ok arriving during CALC,
    // plus up/down presses in the show states.
    press_n(0, 7);
    press(2);
    chk("b_kept2", 8'(leds), 8'd9);
    @(negedge clk);
    ok = 1'b0;
    @(negedge clk);
    ok = 1'b1;
    @(negedge clk);
    ok = 1'b0;
    up = 1'b0;
    nbusy = 0;
    seen  = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (phase == 3'd3) seen = 1'b1;
    end
    ok = 1'b1; up = 1'b1;
    chk("ign_busy_cycles", 8'(nbusy), 8'd4);
    cyc(8);
    chk("ign_lo_phase", 8'(phase), 8'd3);
    chk("ign_lo", 8'(leds), 8'hF);
    press(1);
    chk("ign_down_lo", 8'(leds), 8'hF);
    chk("ign_down_phase", 8'(phase), 8'd3);
    press(2);
    chk("ign_hi", 8'(leds), 8'h3);
    press(0);
    chk("ign_up_hi", 8'(leds), 8'h3);
    press(2);
    chk("ign_a_kept", 8'(leds), 8'd7);
    press(2);
    chk("ign_b_kept", 8'(leds), 8'd9);

    // Reset in the second CALC cycle
    @(negedge clk);
    ok = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    ok = 1'b1;
    chk("mid_busy_seen", 8'(seen), 8'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_phase", 8'(phase), 8'd0);
    chk("mid_rst_leds", 8'(leds), 8'd0);
    chk("mid_rst_busy", 8'(busy), 8'd0);
    cyc(2);
    rst = 1'b1;
    cyc(5);
    chk("mid_a_zero", 8'(leds), 8'd0);
    press_n(0, 2);
    press(2);
    chk("mid_b_zero", 8'(leds), 8'd0);
    press_n(0, 3);
    run_calc("m2x3", 4'h6, 4'h0, 4'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
